vga_card_mover: RTL and testbench

Hardware animator that slides one card sprite from a start to a target screen position, one step per frame. It sits directly upstream of the card sprite core's video-slot interface and merges its own register writes with the processor's slot traffic. Per-frame position updates happen at the start of vertical blank, so the sprite never tears. The processor issues one command and then waits for `done`.

---
 rtl/vga_card_mover.sv | 170 +++++++++++++++++
 tb/tb_vga_card_mover.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_card_mover.sv
// vga_card_mover: slides one card sprite from a start to a target position,
// one step per frame, updating the sprite core's x0/y0 registers at the start
// of vertical blank. Processor slot traffic always wins the shared slot bus.
module vga_card_mover #(
  parameter int          VBLANK_Y   = 480,
  parameter logic [13:0] REG_X0     = 14'h2001,
  parameter logic [13:0] REG_Y0     = 14'h2002,
  parameter logic [13:0] REG_BYPASS = 14'h2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [10:0] cmd_x0,
  input  logic [10:0] cmd_y0,
  input  logic [10:0] cmd_x1,
  input  logic [10:0] cmd_y1,
  input  logic [3:0]  cmd_step,
  input  logic        cmd_hide,
  output logic        busy,
  output logic        done,
  input  logic        p_cs,
  input  logic        p_write,
  input  logic [13:0] p_addr,
  input  logic [31:0] p_wr_data,
  output logic        s_cs,
  output logic        s_write,
  output logic [13:0] s_addr,
  output logic [31:0] s_wr_data
);

  localparam logic [10:0] VB_LINE = 11'(VBLANK_Y);

  typedef enum logic [3:0] {
    IDLE, WR_SX, WR_SY, WR_SHOW, WAIT_VB, STEP, WR_X, WR_Y, WR_HIDE, FIN
  } state_t;

  state_t      state, state_nx;
  logic [10:0] cur_x, cur_y, tgt_x, tgt_y, step;
  logic        hide;
  logic        vb, vb_d, tick;
  logic        mv_wr, issued, arrived;
  logic [13:0] mv_addr;
  logic [31:0] mv_data;

  // Moves one axis toward its target by at most stp, landing exactly on it.
  function automatic logic [10:0] approach(input logic [10:0] cur,
                                           input logic [10:0] tgt,
                                           input logic [10:0] stp);
    logic [10:0] res;
    if (tgt >= cur) res = ((tgt - cur) <= stp) ? tgt : cur + stp;
    else            res = ((cur - tgt) <= stp) ? tgt : cur - stp;
    return res;
  endfunction

  assign vb      = (y == VB_LINE) && (x == 11'd0);
  assign tick    = vb & ~vb_d;
  assign arrived = (cur_x == tgt_x) && (cur_y == tgt_y);
  assign issued  = mv_wr & ~p_cs;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

  // State register; reset aborts any move immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; write states only advance once their write is issued.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cmd_valid) state_nx = WR_SX;
      WR_SX:   if (issued) state_nx = WR_SY;
      WR_SY:   if (issued) state_nx = WR_SHOW;
      WR_SHOW: if (issued) state_nx = WAIT_VB;
      WAIT_VB: if (tick) state_nx = STEP;
      STEP:    state_nx = WR_X;
      WR_X:    if (issued) state_nx = WR_Y;
      WR_Y: begin
        if (issued) begin
          if (!arrived)  state_nx = WAIT_VB;
          else if (hide) state_nx = WR_HIDE;
          else           state_nx = FIN;
        end
      end
      WR_HIDE: if (issued) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Command latch, per-frame position update and vblank edge history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_x <= '0;
      cur_y <= '0;
      tgt_x <= '0;
      tgt_y <= '0;
      step  <= '0;
      hide  <= 1'b0;
      vb_d  <= 1'b0;
    end else begin
      vb_d <= vb;
      if (state == IDLE && cmd_valid) begin
        cur_x <= cmd_x0;
        cur_y <= cmd_y0;
        tgt_x <= cmd_x1;
        tgt_y <= cmd_y1;
        step  <= (cmd_step == 4'd0) ? 11'd1 : {7'd0, cmd_step};
        hide  <= cmd_hide;
      end else if (state == STEP) begin
        cur_x <= approach(cur_x, tgt_x, step);
        cur_y <= approach(cur_y, tgt_y, step);
      end
    end
  end

  // Register write the mover wants to make in its current state.
  always_comb begin
    mv_wr   = 1'b0;
    mv_addr = REG_X0;
    mv_data = '0;
    case (state)
      WR_SX, WR_X: begin
        mv_wr   = 1'b1;
        mv_addr = REG_X0;
        mv_data = {21'd0, cur_x};
      end
      WR_SY, WR_Y: begin
        mv_wr   = 1'b1;
        mv_addr = REG_Y0;
        mv_data = {21'd0, cur_y};
      end
      WR_SHOW: begin
        mv_wr   = 1'b1;
        mv_addr = REG_BYPASS;
        mv_data = 32'd0;
      end
      WR_HIDE: begin
        mv_wr   = 1'b1;
        mv_addr = REG_BYPASS;
        mv_data = 32'd1;
      end
      default: ;
    endcase
  end

  // Slot bus merge: processor first, then the mover, otherwise an idle bus.
  always_comb begin
    s_cs      = 1'b0;
    s_write   = 1'b0;
    s_addr    = p_addr;
    s_wr_data = p_wr_data;
    if (p_cs) begin
      s_cs    = 1'b1;
      s_write = p_write;
    end else if (mv_wr) begin
      s_cs      = 1'b1;
      s_write   = 1'b1;
      s_addr    = mv_addr;
      s_wr_data = mv_data;
    end
  end

endmodule

// File: tb/tb_vga_card_mover.sv
// tb_vga_card_mover: drives commands and a synthetic raster, and compares the
// mover's slot writes against a per-frame position model.
module tb_vga_card_mover;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x, y;
  logic        cmd_valid, cmd_ready;
  logic [10:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
  logic [3:0]  cmd_step;
  logic        cmd_hide;
  logic        busy, done;
  logic        p_cs, p_write;
  logic [13:0] p_addr;
  logic [31:0] p_wr_data;
  logic        s_cs, s_write;
  logic [13:0] s_addr;
  logic [31:0] s_wr_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_count = 0;
  int done_cyc = 0;
  bit stall_en = 0;
  bit collide_en = 0;

  logic [13:0] obs_addr[$];
  logic [31:0] obs_data[$];
  int          obs_cyc[$];
  logic [13:0] exp_addr[$];
  logic [31:0] exp_data[$];

  vga_card_mover dut (
    .clk(clk), .reset(reset), .x(x), .y(y),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_step(cmd_step), .cmd_hide(cmd_hide), .busy(busy), .done(done),
    .p_cs(p_cs), .p_write(p_write), .p_addr(p_addr), .p_wr_data(p_wr_data),
    .s_cs(s_cs), .s_write(s_write), .s_addr(s_addr), .s_wr_data(s_wr_data)
  );

  // 10 ns system clock.
  always #5 clk = ~clk;

  // Cycle counter used to time writes and done.
  always @(posedge clk) cyc <= cyc + 1;

  // Counts one comparison and reports it if the values differ.
  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Bus monitor: processor cycles must pass through, other strobes are mover writes.
  always @(negedge clk) begin
    if (p_cs)
      check_output("proc_passthru", {16'd0, s_cs, s_write, s_addr, s_wr_data},
                   {16'd0, 1'b1, p_write, p_addr, p_wr_data});
    else if (s_cs && s_write) begin
      obs_addr.push_back(s_addr);
      obs_data.push_back(s_wr_data);
      obs_cyc.push_back(cyc);
    end
    if (done) begin
      done_count++;
      done_cyc = cyc;
    end
  end

  // Advances one negedge, optionally injecting random processor cycles.
  task automatic raster_wait(input int n);
    repeat (n) begin
      @(negedge clk);
      if (stall_en && $urandom_range(0, 7) == 0) begin
        p_cs      = 1'b1;
        p_write   = 1'($urandom_range(0, 1));
        p_addr    = 14'($urandom_range(0, 16'h1fff));
        p_wr_data = $urandom;
      end else p_cs = 1'b0;
    end
  endtask

  // Synthetic raster: a short active region then a vblank line start.
  task automatic raster_loop();
    forever begin
      x = 11'd5; y = 11'd0;
      raster_wait(8);
      x = 11'd0; y = 11'd480;
      if (collide_en) begin
        raster_wait(2);
        p_cs = 1'b1; p_write = 1'b1; p_addr = 14'h0155; p_wr_data = 32'h1234_5678;
        repeat (3) @(negedge clk);
        p_cs = 1'b0;
      end else raster_wait(3);
      x = 11'd1;
      raster_wait(3);
    end
  endtask

  // Builds the expected write list for a move: start writes, one x/y pair per
  // frame at min(k*step, distance) from the start, then the optional hide.
  task automatic build_expected(input int x0, y0, x1, y1, stp, hd);
    int s, dx, dy, adx, ady, n, px, py;
    s   = (stp == 0) ? 1 : stp;
    dx  = x1 - x0;
    dy  = y1 - y0;
    adx = (dx < 0) ? -dx : dx;
    ady = (dy < 0) ? -dy : dy;
    n   = (adx + s - 1) / s;
    if ((ady + s - 1) / s > n) n = (ady + s - 1) / s;
    if (n < 1) n = 1;
    exp_addr.delete(); exp_data.delete();
    exp_addr.push_back(14'h2001); exp_data.push_back(32'(x0));
    exp_addr.push_back(14'h2002); exp_data.push_back(32'(y0));
    exp_addr.push_back(14'h2000); exp_data.push_back(32'd0);
    for (int k = 1; k <= n; k++) begin
      px = x0 + ((dx < 0) ? -1 : 1) * ((k * s < adx) ? k * s : adx);
      py = y0 + ((dy < 0) ? -1 : 1) * ((k * s < ady) ? k * s : ady);
      exp_addr.push_back(14'h2001); exp_data.push_back(32'(px));
      exp_addr.push_back(14'h2002); exp_data.push_back(32'(py));
    end
    if (hd != 0) begin
      exp_addr.push_back(14'h2000); exp_data.push_back(32'd1);
    end
  endtask

  // Issues one command and checks its handshake.
  task automatic apply_stimulus(input int x0, y0, x1, y1, stp, hd, output int acc_cyc);
    int g = 0;
    while (!cmd_ready && g < 2000) begin @(negedge clk); g++; end
    check_output("ready_before_cmd", cmd_ready, 1);
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    done_count = 0;
    cmd_x0 = 11'(x0); cmd_y0 = 11'(y0); cmd_x1 = 11'(x1); cmd_y1 = 11'(y1);
    cmd_step = 4'(stp); cmd_hide = 1'(hd);
    cmd_valid = 1'b1;
    acc_cyc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_output("busy_after_accept", busy, 1);
    check_output("ready_after_accept", cmd_ready, 0);
  endtask

  // Runs one full move and compares the write stream with the model.
  task automatic run_move(input int x0, y0, x1, y1, stp, hd);
    int acc, g, n;
    build_expected(x0, y0, x1, y1, stp, hd);
    apply_stimulus(x0, y0, x1, y1, stp, hd, acc);
    g = 0;
    while (done_count == 0 && g < 6000) begin @(negedge clk); g++; end
    check_output("done_seen", (done_count > 0), 1);
    @(negedge clk);
    check_output("done_pulse_count", done_count, 1);
    check_output("busy_after_done", busy, 0);
    check_output("ready_after_done", cmd_ready, 1);
    check_output("write_count", obs_addr.size(), exp_addr.size());
    n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check_output($sformatf("wr%0d_addr", i), obs_addr[i], exp_addr[i]);
      check_output($sformatf("wr%0d_data", i), obs_data[i], exp_data[i]);
    end
    if (obs_cyc.size() > 0) begin
      check_output("done_after_last_write", done_cyc - obs_cyc[obs_cyc.size() - 1], 1);
      if (!stall_en) check_output("first_write_latency", obs_cyc[0] - acc, 1);
    end
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int acc, g, n_at;
    reset = 1'b1;
    x = 11'd5; y = 11'd0;
    cmd_valid = 1'b0; cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0;
    cmd_step = '0; cmd_hide = 1'b0;
    p_cs = 1'b1; p_write = 1'b1; p_addr = 14'h0123; p_wr_data = 32'hdead_beef;
    repeat (3) @(negedge clk);
    check_output("rst_ready", cmd_ready, 1);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_s_cs_follows", s_cs, 1);
    p_cs = 1'b0; p_write = 1'b0;
    @(negedge clk);
    check_output("rst_s_cs_idle", {s_cs, s_write}, 2'b00);
    reset = 1'b0;
    @(negedge clk);
    fork raster_loop(); join_none

    run_move(100, 50, 120, 50, 4, 0);
    run_move(300, 200, 290, 171, 0, 0);
    run_move(0, 0, 10, 7, 4, 0);
    run_move(5, 5, 5, 5, 3, 1);
    collide_en = 1;
    run_move(400, 300, 420, 310, 5, 0);
    collide_en = 0;

    apply_stimulus(0, 0, 200, 0, 1, 0, acc);
    g = 0;
    while (obs_addr.size() < 7 && g < 2000) begin @(negedge clk); g++; end
    check_output("two_ticks_reached", (obs_addr.size() >= 7), 1);
    reset = 1'b1;
    #1;
    check_output("midrst_busy", busy, 0);
    check_output("midrst_ready", cmd_ready, 1);
    n_at = obs_addr.size();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    check_output("midrst_no_writes", obs_addr.size(), n_at);
    check_output("midrst_no_done", done_count, 0);
    run_move(500, 100, 480, 130, 6, 1);

    stall_en = 1;
    for (int i = 0; i < 8; i++) begin
      int rx0, ry0;
      rx0 = $urandom_range(100, 1900);
      ry0 = $urandom_range(100, 1900);
      run_move(rx0, ry0, rx0 + $urandom_range(0, 80) - 40, ry0 + $urandom_range(0, 80) - 40,
               $urandom_range(0, 15), $urandom_range(0, 1));
    end
    stall_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
